// File: rtl/group_payout_if.sv
// Bus between the game FSM/selector side and the group_payout block.
// The master modport drives the game inputs; the slave modport drives the score/status outputs.
interface group_payout_if #(
    parameter int unsigned SCORE_W = 10
);
    logic [2:0]         i_state;
    logic [2:0]         i_selected_group;
    logic               i_flash_clk;
    logic [SCORE_W-1:0] o_score;
    logic [2:0]         o_balls_left;
    logic               o_payout_busy;
    logic               o_payout_done;
    logic               o_game_over;
    logic [2:0]         o_lit_group;
    logic [SCORE_W-1:0] o_high_score;

    modport master (
        output i_state, i_selected_group, i_flash_clk,
        input  o_score, o_balls_left, o_payout_busy, o_payout_done, o_game_over,
        input  o_lit_group, o_high_score
    );

    modport slave (
        input  i_state, i_selected_group, i_flash_clk,
        output o_score, o_balls_left, o_payout_busy, o_payout_done, o_game_over,
        output o_lit_group, o_high_score
    );
endinterface

// File: rtl/group_payout.sv
// Pays out the selected group as points, one per flash tick, and tracks balls left.
// Optional HIGH_SCORE_EN keeps the best game score across game-state resets.
module group_payout #(
    parameter int unsigned BALLS   = 3,
    parameter int unsigned SCORE_W = 10
) (
    input logic           i_clk,
    input logic           i_reset,
    group_payout_if.slave bus
);
    localparam logic [2:0] GameReset = 3'd0;
    localparam logic [2:0] GameGet   = 3'd3;

    typedef enum logic [2:0] {StIdle, StLatch, StCount, StDone, StHold} pay_state_e;

    pay_state_e         r_fsm, w_fsm_d;
    logic [2:0]         r_prev_state;
    logic [2:0]         r_pts_rem, w_pts_rem_d;
    logic [SCORE_W-1:0] r_score, w_score_d;
    logic [2:0]         r_balls_left, w_balls_left_d;
    logic [2:0]         r_lit_group, w_lit_group_d;
    logic               r_game_over, w_game_over_d;
    logic               w_clear;

    function automatic logic [2:0] pts(input logic [2:0] g);
        case (g)
            3'd0: pts = 3'd0;
            3'd1: pts = 3'd1;
            3'd2: pts = 3'd2;
            3'd3: pts = 3'd3;
            3'd4: pts = 3'd5;
            3'd5: pts = 3'd3;
            3'd6: pts = 3'd2;
            default: pts = 3'd1;
        endcase
    endfunction

    assign w_clear = (bus.i_state == GameReset);

    always_comb begin
        w_fsm_d        = r_fsm;
        w_pts_rem_d    = r_pts_rem;
        w_score_d      = r_score;
        w_balls_left_d = r_balls_left;
        w_lit_group_d  = r_lit_group;
        case (r_fsm)
            StIdle: begin
                if (bus.i_state == GameGet && r_prev_state != GameGet) w_fsm_d = StLatch;
            end
            StLatch: begin
                w_pts_rem_d   = pts(bus.i_selected_group);
                w_lit_group_d = bus.i_selected_group;
                w_fsm_d       = StCount;
            end
            StCount: begin
                // Exit test uses the start-of-cycle count so group 0 needs no tick.
                if (r_pts_rem == 3'd0) begin
                    w_fsm_d = StDone;
                end else if (bus.i_flash_clk) begin
                    w_pts_rem_d = r_pts_rem - 3'd1;
                    if (r_score != {SCORE_W{1'b1}}) begin
                        w_score_d = r_score + {{(SCORE_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            StDone: begin
                if (r_balls_left != 3'd0) w_balls_left_d = r_balls_left - 3'd1;
                w_lit_group_d = 3'd0;
                w_fsm_d       = StHold;
            end
            StHold: begin
                if (bus.i_state != GameGet) w_fsm_d = StIdle;
            end
            default: w_fsm_d = StIdle;
        endcase
        if (w_clear) begin
            w_fsm_d        = StIdle;
            w_pts_rem_d    = 3'd0;
            w_score_d      = '0;
            w_balls_left_d = 3'(BALLS);
            w_lit_group_d  = 3'd0;
        end
        // Computed from next balls_left so game_over shows the cycle after DONE.
        w_game_over_d = !w_clear && (w_balls_left_d == 3'd0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fsm        <= StIdle;
            r_prev_state <= GameReset;
            r_pts_rem    <= 3'd0;
            r_score      <= '0;
            r_balls_left <= 3'(BALLS);
            r_lit_group  <= 3'd0;
            r_game_over  <= 1'b0;
        end else begin
            r_fsm        <= w_fsm_d;
            r_prev_state <= bus.i_state;
            r_pts_rem    <= w_pts_rem_d;
            r_score      <= w_score_d;
            r_balls_left <= w_balls_left_d;
            r_lit_group  <= w_lit_group_d;
            r_game_over  <= w_game_over_d;
        end
    end

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] r_high_score;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_high_score <= '0;
        end else if (w_game_over_d && !r_game_over && (r_score > r_high_score)) begin
            r_high_score <= r_score;
        end
    end

    assign bus.o_high_score = r_high_score;
`else
    assign bus.o_high_score = '0;
`endif

    assign bus.o_score       = r_score;
    assign bus.o_balls_left  = r_balls_left;
    assign bus.o_lit_group   = r_lit_group;
    assign bus.o_game_over   = r_game_over;
    assign bus.o_payout_busy = (r_fsm == StLatch) || (r_fsm == StCount) || (r_fsm == StDone);
    assign bus.o_payout_done = (r_fsm == StDone);
endmodule

// File: tb/tb_group_payout.sv
// Scoreboard bench for group_payout: driver predicts each payout, monitor checks on payout_done.
module tb_group_payout;
    localparam int unsigned SW    = 4;
    localparam int unsigned BALLS = 3;
    localparam int          MAXS  = (1 << SW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    group_payout_if #(.SCORE_W(SW)) bus ();
    group_payout #(.BALLS(BALLS), .SCORE_W(SW)) dut (.i_clk(clk), .i_reset(reset), .bus(bus));

    typedef struct {
        int score;
        int balls;
        int grp;
        int over;
        int high;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   pts_tab[8] = '{0, 1, 2, 3, 5, 3, 2, 1};
    int   m_score, m_balls, m_over, m_high;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic void model_reset(input bit hard);
        m_score = 0;
        m_balls = BALLS;
        m_over  = 0;
        if (hard) m_high = 0;
    endfunction

    function automatic void predict(input int g);
        exp_t e;
        m_score = (m_score + pts_tab[g] > MAXS) ? MAXS : m_score + pts_tab[g];
        if (m_balls > 0) m_balls--;
        if (m_balls == 0 && m_over == 0) begin
            m_over = 1;
`ifdef HIGH_SCORE_EN
            if (m_score > m_high) m_high = m_score;
`endif
        end
        e = '{m_score, m_balls, g, m_over, m_high};
        q.push_back(e);
    endfunction

    // Monitor: every payout_done must match the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.o_payout_done === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("done_score", int'(bus.o_score), e.score);
                    check("done_lit", int'(bus.o_lit_group), e.grp);
                    @(negedge clk);
                    check("post_balls", int'(bus.o_balls_left), e.balls);
                    check("post_game_over", int'(bus.o_game_over), e.over);
                    check("post_lit_zero", int'(bus.o_lit_group), 0);
                    check("post_high", int'(bus.o_high_score), e.high);
                    check("done_pulse_len", int'(bus.o_payout_done), 0);
                end
            end
        end
    end

    task automatic state_reset();
        @(posedge clk) #1;
        bus.i_state = 3'd0;
        @(posedge clk) #1;
        bus.i_state = 3'd1;
        model_reset(1'b0);
        repeat (2) @(posedge clk);
    endtask

    // mode 0: plain; 1: leave GET early and re-enter while busy; 2: abort with state RESET.
    // flash_pct < 0 gives a tick every 4th cycle.
    task automatic do_get(input int g, input int flash_pct, input int mode, output int done_cyc);
        int cyc = 0;
        bit seen_busy = 1'b0;
        done_cyc = -1;
        if (mode != 2) predict(g);
        @(posedge clk) #1;
        bus.i_state          = 3'd3;
        bus.i_selected_group = 3'(g);
        forever begin
            @(posedge clk) #1;
            cyc++;
            if (flash_pct < 0) bus.i_flash_clk = (cyc % 4 == 0);
            else bus.i_flash_clk = ($urandom_range(99) < flash_pct);
            if (bus.o_payout_done && done_cyc < 0) done_cyc = cyc;
            if (cyc == 2) begin
                check("busy_in_count", int'(bus.o_payout_busy), 1);
                check("lit_in_count", int'(bus.o_lit_group), g);
                bus.i_selected_group = 3'($urandom_range(7));
            end
            if (mode == 1 && cyc == 3) bus.i_state = 3'd1;
            if (mode == 1 && cyc == 5 && bus.o_payout_busy) bus.i_state = 3'd3;
            if (mode == 2 && cyc == 3) bus.i_state = 3'd0;
            if (mode == 2 && cyc == 4) begin
                model_reset(1'b0);
                check("abort_score", int'(bus.o_score), 0);
                check("abort_balls", int'(bus.o_balls_left), BALLS);
                check("abort_busy", int'(bus.o_payout_busy), 0);
                check("abort_lit", int'(bus.o_lit_group), 0);
                break;
            end
            if (bus.o_payout_busy) seen_busy = 1'b1;
            if (seen_busy && !bus.o_payout_busy) break;
            if (cyc > 300) begin
                check("payout_timeout", cyc, 0);
                break;
            end
        end
        bus.i_flash_clk = 1'b0;
        bus.i_state     = 3'd1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int dc;
        int grp_seq[6] = '{1, 2, 3, 1, 2, 4};
        reset                = 1'b1;
        bus.i_state          = 3'd0;
        bus.i_selected_group = 3'd0;
        bus.i_flash_clk      = 1'b0;
        model_reset(1'b1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        bus.i_state = 3'd1;
        @(negedge clk);
        check("rst_score", int'(bus.o_score), 0);
        check("rst_balls", int'(bus.o_balls_left), BALLS);
        check("rst_game_over", int'(bus.o_game_over), 0);
        check("rst_lit", int'(bus.o_lit_group), 0);
        check("rst_busy", int'(bus.o_payout_busy), 0);
        check("rst_high", int'(bus.o_high_score), 0);
        repeat (2) @(posedge clk);

        do_get(4, -1, 0, dc);
        do_get(0, 0, 0, dc);
        check("grp0_done_latency", int'(dc >= 1 && dc <= 3), 1);

        // Full game 1,2,3 then bonus payouts past game over into saturation.
        state_reset();
        foreach (grp_seq[i]) do_get(grp_seq[i], 60, 0, dc);
        do_get(4, 100, 0, dc);

        state_reset();
        do_get(4, 50, 0, dc);
        do_get(3, 50, 1, dc);
        do_get(1, 50, 0, dc);
        state_reset();
        do_get(1, 100, 0, dc);
        do_get(2, 30, 0, dc);
        do_get(3, 70, 0, dc);

        do_get(4, 0, 2, dc);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(9) == 0) state_reset();
            do_get(int'($urandom_range(7)), int'($urandom_range(100, 10)),
                   int'($urandom_range(1)), dc);
        end
        do_get(5, 50, 2, dc);

        @(posedge clk) #1 reset = 1'b1;
        @(posedge clk) #1 reset = 1'b0;
        model_reset(1'b1);
        @(negedge clk);
        check("hard_rst_high", int'(bus.o_high_score), 0);
        check("hard_rst_score", int'(bus.o_score), 0);
        do_get(6, 80, 0, dc);

        repeat (5) @(posedge clk);
        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
